// File: rtl/muldiv_seq_if.sv
// Operand/result bus of the multiply/divide sequencer, including the borrowed ALU port.
// The pipeline side uses master and the sequencer uses slave.
interface muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wdata;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_own;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opa, opb, wr_hi, wr_lo, wdata, alu_c,
    input  alu_a, alu_b, alu_op, alu_own, busy, done, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, wr_hi, wr_lo, wdata, alu_c,
    output alu_a, alu_b, alu_op, alu_own, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU through the shared ALU. Owns HI/LO.
// Result is ready 33 cycles after start is accepted; start is ignored while an operation runs.
module muldiv_seq #(
  parameter int         ITER       = 32,
  parameter logic [4:0] ALUOP_ADDU = 5'd1,
  parameter logic [4:0] ALUOP_SUBU = 5'd2
) (
  input  logic        clk,
  input  logic        rstn,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_q, op_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_op;
  logic        alu_own, busy, done;
  logic [31:0] t;
  logic        carry;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_own = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    // Divide step: partial remainder shifted left by one, next dividend bit brought in.
    t       = {hi_q[30:0], lo_q[31]};
    // An ADDU wrapped iff the sum came out smaller than an addend.
    carry   = (bus.alu_c < hi_q);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          count_d = '0;
          op_d    = bus.op;
          opnd_d  = bus.opb;
          hi_d    = '0;
          lo_d    = bus.opa;
        end else begin
          if (bus.wr_hi) hi_d = bus.wdata;
          if (bus.wr_lo) lo_d = bus.wdata;
        end
      end
      RUN: begin
        alu_own = 1'b1;
        busy    = 1'b1;
        alu_b   = opnd_q;
        if (!op_q) begin
          alu_a  = hi_q;
          alu_op = ALUOP_ADDU;
          if (lo_q[0]) begin
            hi_d = {carry, bus.alu_c[31:1]};
            lo_d = {bus.alu_c[0], lo_q[31:1]};
          end else begin
            hi_d = {1'b0, hi_q[31:1]};
            lo_d = {hi_q[0], lo_q[31:1]};
          end
        end else begin
          alu_a  = t;
          alu_op = ALUOP_SUBU;
          // hi[31] set means the shifted remainder is a 33-bit value, always >= divisor.
          if (hi_q[31] || (t >= opnd_q)) begin
            hi_d = bus.alu_c;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = t;
            lo_d = {lo_q[30:0], 1'b0};
          end
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(ITER - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (bus.wr_hi) hi_d = bus.wdata;
        if (bus.wr_lo) lo_d = bus.wdata;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_op  = alu_op;
  assign bus.alu_own = alu_own;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule
